// File: rtl/operand_pkg.sv
// Shared types and constants for the operand loader and its FIFO.
package operand_pkg;

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  localparam int NIB_W           = 4;
  localparam int OP_W            = 8;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/operand_fifo.sv
// First-word fall-through FIFO of packed operand bytes with synchronous flush.
module operand_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Synchronizes pin nibbles and strobe, pairs A then B into {B, A} bytes and
// buffers them for the adder stage over a valid/ready handshake.
module operand_loader
  import operand_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NIB_W-1:0]         nib_in,
  input  logic                     nib_stb,
  input  logic                     clear,
  output logic [OP_W-1:0]          op_data,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     expect_b,
  output logic                     overflow
);

  // Handshake: a byte transfers on every clk edge where op_valid and
  // op_ready are both high; op_data holds the head while op_valid is high.

  logic [NIB_W-1:0]     nib_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] stb_sync;
  logic                 stb_prev;
  logic [SYNC_STAGES:0] prime;
  logic                 stb_rise;
  logic [NIB_W-1:0]     nib_now;

  state_t               state;
  logic [NIB_W-1:0]     a_reg;
  logic                 push_req;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) nib_sync[i] <= '0;
      stb_sync <= '0;
      stb_prev <= 1'b0;
      prime    <= '0;
    end else begin
      nib_sync[0] <= nib_in;
      for (int i = 1; i < SYNC_STAGES; i++) nib_sync[i] <= nib_sync[i-1];
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], nib_stb};
      stb_prev <= stb_sync[SYNC_STAGES-1];
      prime    <= {prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are only trusted once the chain and stb_prev hold real pin samples,
  // so a strobe already high at reset release is not mistaken for a rise.
  assign stb_rise = stb_sync[SYNC_STAGES-1] & ~stb_prev & prime[SYNC_STAGES];
  assign nib_now  = nib_sync[SYNC_STAGES-1];

  assign pop      = op_valid & op_ready;
  assign push_req = stb_rise & (state == WAIT_B) & ~clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= WAIT_A;
      a_reg    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= WAIT_A;
      a_reg    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
      case (state)
        WAIT_A: begin
          if (stb_rise) begin
            a_reg <= nib_now;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (stb_rise) state <= WAIT_A;
        end
        default: state <= WAIT_A;
      endcase
    end
  end

  assign expect_b = (state == WAIT_B);
  assign op_valid = ~fifo_empty;

  operand_fifo #(
    .DEPTH (DEPTH),
    .W     (OP_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .push      (push_req),
    .push_data ({nib_now, a_reg}),
    .pop       (op_ready),
    .head      (op_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: table of pair entries plus hand-written
// sequences for full-with-pop, clear, strobe qualification and async reset.
module tb_operand_loader;

  logic       clk;
  logic       reset;
  logic [3:0] nib_in;
  logic       nib_stb;
  logic       clear;
  logic [7:0] op_data;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] fifo_count;
  logic       expect_b;
  logic       overflow;

  int n_vec  = 0;
  int n_miss = 0;

  operand_loader #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .nib_in     (nib_in),
    .nib_stb    (nib_stb),
    .clear      (clear),
    .op_data    (op_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .fifo_count (fifo_count),
    .expect_b   (expect_b),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] head;
    logic [2:0] cnt;
    logic       ov;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pin protocol: data settles 3 cycles, strobe 2 high + 2 low.
  task automatic enter_nib(input logic [3:0] v);
    nib_in = v;
    repeat (3) @(negedge clk);
    nib_stb = 1'b1;
    repeat (2) @(negedge clk);
    nib_stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic enter_pair(input logic [3:0] a, input logic [3:0] b);
    enter_nib(a);
    enter_nib(b);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic drain(input string name);
    op_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check({name, "_valid"}, op_valid, 1);
      check({name, "_data"}, op_data, exp_q.pop_front());
      @(negedge clk);
    end
    op_ready = 1'b0;
    check({name, "_empty"}, op_valid, 0);
    check({name, "_count0"}, fifo_count, 0);
  endtask

  initial begin
    vecs[0] = '{clr: 1'b0, a: 4'h3, b: 4'h9, head: 8'h93, cnt: 3'd1, ov: 1'b0};
    vecs[1] = '{clr: 1'b1, a: 4'h1, b: 4'h2, head: 8'h21, cnt: 3'd1, ov: 1'b0};
    vecs[2] = '{clr: 1'b0, a: 4'h3, b: 4'h4, head: 8'h21, cnt: 3'd2, ov: 1'b0};
    vecs[3] = '{clr: 1'b0, a: 4'h5, b: 4'h6, head: 8'h21, cnt: 3'd3, ov: 1'b0};
    vecs[4] = '{clr: 1'b0, a: 4'h7, b: 4'h8, head: 8'h21, cnt: 3'd4, ov: 1'b0};
    vecs[5] = '{clr: 1'b0, a: 4'h9, b: 4'hA, head: 8'h21, cnt: 3'd4, ov: 1'b1};

    reset = 1'b1; nib_in = 4'h0; nib_stb = 1'b0; clear = 1'b0; op_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", op_valid, 0);
    check("rst_data", op_data, 8'h00);
    check("rst_count", fifo_count, 0);
    check("rst_expect_b", expect_b, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table: each entry enters one pair with op_ready low.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].clr) begin
        pulse_clear();
        check($sformatf("v%0d_clr_count", i), fifo_count, 0);
      end
      enter_nib(vecs[i].a);
      check($sformatf("v%0d_expect_b_hi", i), expect_b, 1);
      enter_nib(vecs[i].b);
      check($sformatf("v%0d_expect_b_lo", i), expect_b, 0);
      check($sformatf("v%0d_valid", i), op_valid, 1);
      check($sformatf("v%0d_head", i), op_data, vecs[i].head);
      check($sformatf("v%0d_count", i), fifo_count, vecs[i].cnt);
      check($sformatf("v%0d_overflow", i), overflow, vecs[i].ov);
    end
    exp_q = '{8'h21, 8'h43, 8'h65, 8'h87};
    drain("drain1");
    check("ov_sticky", overflow, 1);

    // Full FIFO with a pop in the same cycle B is captured.
    pulse_clear();
    check("clr_ov", overflow, 0);
    enter_pair(4'h1, 4'h2);
    enter_pair(4'h3, 4'h4);
    enter_pair(4'h5, 4'h6);
    enter_pair(4'h7, 4'h8);
    check("full_count", fifo_count, 4);
    enter_nib(4'hB);
    nib_in = 4'hC;
    repeat (3) @(negedge clk);
    nib_stb = 1'b1;
    repeat (2) @(negedge clk);
    op_ready = 1'b1;
    nib_stb = 1'b0;
    @(negedge clk);
    op_ready = 1'b0;
    check("fullpop_count", fifo_count, 4);
    check("fullpop_ov", overflow, 0);
    check("fullpop_head", op_data, 8'h43);
    exp_q = '{8'h43, 8'h65, 8'h87, 8'hCB};
    drain("drain2");

    // clear drops a pending A nibble.
    enter_nib(4'hF);
    check("pendA_expect_b", expect_b, 1);
    pulse_clear();
    check("clrA_expect_b", expect_b, 0);
    enter_pair(4'h1, 4'h2);
    check("clrA_head", op_data, 8'h21);
    check("clrA_count", fifo_count, 1);
    pulse_clear();

    // Strobe high across reset release is not a rise.
    reset = 1'b1; nib_in = 4'h5; nib_stb = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("stbhi_expect_b", expect_b, 0);
    check("stbhi_valid", op_valid, 0);
    nib_stb = 1'b0;
    repeat (3) @(negedge clk);

    // Runt strobe between sampling edges is not captured.
    nib_in = 4'h6;
    repeat (3) @(negedge clk);
    #1 nib_stb = 1'b1;
    #2 nib_stb = 1'b0;
    repeat (5) @(negedge clk);
    check("runt_expect_b", expect_b, 0);
    enter_nib(4'h6);
    check("ok_expect_b", expect_b, 1);
    enter_nib(4'h7);
    check("ok_head", op_data, 8'h76);
    pulse_clear();

    // Async reset mid-pair.
    enter_pair(4'h1, 4'h2);
    enter_pair(4'h3, 4'h4);
    enter_nib(4'h7);
    check("mid_count", fifo_count, 2);
    check("mid_expect_b", expect_b, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", op_valid, 0);
    check("arst_data", op_data, 8'h00);
    check("arst_count", fifo_count, 0);
    check("arst_expect_b", expect_b, 0);
    check("arst_overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    enter_pair(4'h4, 4'h5);
    check("post_head", op_data, 8'h54);
    check("post_count", fifo_count, 1);
    check("post_valid", op_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
